// File: rtl/ddr_mm2s_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ddr_mm2s_pkg
// Brief   : Shared types and constants for the DDR MM2S read engine.
// Revision: 1.0 - initial release
// ============================================================================
package ddr_mm2s_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // RAM read latency in cycles (registered output port)
  localparam int RD_LAT = 1;

  // Count must represent 0..depth inclusive
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mm2s_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : mm2s_sync_fifo
// Brief   : Single-clock show-ahead FIFO absorbing RAM read latency.
// Revision: 1.0 - initial release
// ============================================================================
module mm2s_sync_fifo
  import ddr_mm2s_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            i_push,
  input  logic [WIDTH-1:0]                i_wdata,
  input  logic                            i_pop,
  output logic [WIDTH-1:0]                o_rdata,
  output logic [cnt_width(DEPTH)-1:0]     o_count,
  output logic                            o_empty,
  output logic                            o_full
);

  localparam int CW = cnt_width(DEPTH);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= r_wptr + PW'(1);
      end
      if (w_do_pop) r_rptr <= r_rptr + PW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - CW'(1);
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!rstn) !(i_push && o_full));

endmodule
`default_nettype wire

// File: rtl/ddr_mm2s_reader.sv
`default_nettype none
// ============================================================================
// Module  : ddr_mm2s_reader
// Brief   : Reads a contiguous RAM block and emits it as an AXI4-Stream.
// Revision: 1.0 - initial release
// ============================================================================
module ddr_mm2s_reader
  import ddr_mm2s_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   xfer_len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic                  ram_re,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  localparam int CW = cnt_width(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0]   c_LEN_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE = 1;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_len;
  logic [ADDR_WIDTH:0]   r_issue_cnt;
  logic [ADDR_WIDTH:0]   r_beat_cnt;
  logic [RD_LAT-1:0]     r_infl;
  logic [CW-1:0]         w_count;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_credit;
  logic                  w_pop;
  logic                  w_drained;
  logic                  w_accept;

  // Outstanding reads already hold a FIFO slot, so overflow is impossible
  assign w_credit  = ~w_full && ((int'(w_count) + $countones(r_infl)) < FIFO_DEPTH);
  assign w_pop     = ~w_empty & m_axis_tready;
  assign w_drained = (r_infl == '0) && (w_empty || (w_count == CW'(1) && w_pop));
  assign w_accept  = (r_state == IDLE) && start;

  assign ram_raddr     = r_addr;
  assign m_axis_tvalid = ~w_empty;
  assign m_axis_tlast  = ~w_empty && (r_beat_cnt == r_len - c_LEN_ONE);

  always_comb begin
    w_next = r_state;
    ram_re = 1'b0;
    done   = 1'b0;
    busy   = (r_state != IDLE);
    unique case (r_state)
      IDLE:  if (start) w_next = (xfer_len == '0) ? DONE : READ;
      READ: begin
        ram_re = w_credit;
        if (w_credit && (r_issue_cnt == r_len - c_LEN_ONE)) w_next = DRAIN;
      end
      DRAIN: if (w_drained) w_next = DONE;
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_len       <= '0;
      r_issue_cnt <= '0;
      r_beat_cnt  <= '0;
      r_infl      <= '0;
    end else begin
      r_state <= w_next;
      r_infl  <= (r_infl << 1) | RD_LAT'(ram_re);
      if (w_accept) begin
        if (xfer_len != '0) r_addr <= start_addr;
        r_len       <= xfer_len;
        r_issue_cnt <= '0;
        r_beat_cnt  <= '0;
      end else begin
        if (ram_re) begin
          r_addr      <= r_addr + c_ADDR_ONE;
          r_issue_cnt <= r_issue_cnt + c_LEN_ONE;
        end
        if (w_pop) r_beat_cnt <= r_beat_cnt + c_LEN_ONE;
      end
    end
  end

  mm2s_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (r_infl[RD_LAT-1]),
    .i_wdata (ram_rdata),
    .i_pop   (w_pop),
    .o_rdata (m_axis_tdata),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

endmodule
`default_nettype wire

// File: tb/tb_ddr_mm2s_reader.sv
`default_nettype none
// ============================================================================
// Module  : tb_ddr_mm2s_reader
// Brief   : Directed self-checking bench for ddr_mm2s_reader.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ddr_mm2s_reader;

  localparam int DW = 8;
  localparam int AW = 9;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   xfer_len = '0;
  logic          busy, done, ram_re;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast;
  logic          m_axis_tready = 1'b1;

  logic [DW-1:0] mem [2**AW];
  int cyc = 0;
  int start_cyc = 0;
  int rdy_mode = 0;
  int n_chk = 0;
  int n_pass = 0;

  logic [DW-1:0] dq[$];
  bit            lq[$];
  int            bcq[$];
  logic [AW-1:0] aq[$];
  int            reqc[$];
  int            doneq[$];
  int            first_v = -1;
  int            max_cnt = 0;
  bit            stalled = 1'b0;
  logic [DW-1:0] held = '0;

  ddr_mm2s_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .start         (start),
    .start_addr    (start_addr),
    .xfer_len      (xfer_len),
    .busy          (busy),
    .done          (done),
    .ram_raddr     (ram_raddr),
    .ram_re        (ram_re),
    .ram_rdata     (ram_rdata),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered-output RAM model
  always @(posedge clk) if (ram_re) ram_rdata <= mem[ram_raddr];

  initial forever begin
    @(posedge clk);
    #1;
    m_axis_tready = (rdy_mode == 0) || ((cyc % 4) == 0) || ((cyc % 4) == 3);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (m_axis_tvalid && first_v < 0) first_v = cyc - start_cyc;
      if (ram_re) begin
        aq.push_back(ram_raddr);
        reqc.push_back(cyc - start_cyc);
      end
      if (m_axis_tvalid && stalled) check("hold_tdata", {24'd0, m_axis_tdata}, {24'd0, held});
      if (m_axis_tvalid && m_axis_tready) begin
        dq.push_back(m_axis_tdata);
        lq.push_back(m_axis_tlast);
        bcq.push_back(cyc - start_cyc);
      end
      if (done) doneq.push_back(cyc - start_cyc);
      if (int'(dut.u_fifo.o_count) > max_cnt) max_cnt = int'(dut.u_fifo.o_count);
      stalled = m_axis_tvalid && !m_axis_tready;
      held    = m_axis_tdata;
    end
  end

  task automatic clear_log();
    dq.delete(); lq.delete(); bcq.delete(); aq.delete(); reqc.delete(); doneq.delete();
    first_v = -1;
    max_cnt = 0;
    stalled = 1'b0;
  endtask

  task automatic run_xfer(input string nm, input logic [AW-1:0] a, input int len,
                          input int mode, input bit restart);
    int            bound;
    int            nb;
    logic [AW-1:0] ea;
    logic [AW:0]   lv;
    rdy_mode = mode;
    @(posedge clk);
    #1;
    clear_log();
    start_cyc  = cyc;
    lv         = len[AW:0];
    start      = 1'b1;
    start_addr = a;
    xfer_len   = lv;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({nm, "_busy_on"}, {31'd0, busy}, 32'd1);
    bound = 0;
    while (!done && bound < 8 * len + 40) begin
      if (restart && bound == 3) begin
        start      = 1'b1;
        start_addr = 9'h100;
        xfer_len   = 10'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      bound++;
    end
    start = 1'b0;
    check({nm, "_done_seen"}, {31'd0, done}, 32'd1);
    repeat (12) @(posedge clk);
    #1;
    check({nm, "_busy_off"}, {31'd0, busy}, 32'd0);
    check({nm, "_beats"}, dq.size(), len);
    check({nm, "_reads"}, aq.size(), len);
    nb = (dq.size() < len) ? dq.size() : len;
    for (int i = 0; i < nb; i++) begin
      ea = a + AW'(i);
      check($sformatf("%s_data%0d", nm, i), {24'd0, dq[i]}, {24'd0, ea[DW-1:0]});
      check($sformatf("%s_last%0d", nm, i), {31'd0, lq[i]}, {31'd0, (i == len - 1)});
    end
    for (int i = 0; i < aq.size() && i < len; i++) begin
      ea = a + AW'(i);
      check($sformatf("%s_raddr%0d", nm, i), {23'd0, aq[i]}, {23'd0, ea});
    end
    check({nm, "_done_cnt"}, doneq.size(), 1);
    if (doneq.size() > 0)
      check({nm, "_done_cyc"}, doneq[0], (len == 0 || bcq.size() == 0) ? 1 : bcq[bcq.size()-1] + 1);
    check({nm, "_first_valid"}, first_v, (len == 0) ? -1 : 3);
    check({nm, "_fifo_max"}, {31'd0, (max_cnt <= FD)}, 32'd1);
    if (mode == 0 && len > 0 && bcq.size() == len)
      check({nm, "_last_beat_cyc"}, bcq[len-1], len + 2);
    if (mode == 1 && reqc.size() > 1)
      check({nm, "_re_throttled"}, {31'd0, (reqc[reqc.size()-1] - reqc[0] > len - 1)}, 32'd1);
  endtask

  task automatic reset_mid();
    int bound;
    rdy_mode = 0;
    @(posedge clk);
    #1;
    clear_log();
    start_cyc  = cyc;
    start      = 1'b1;
    start_addr = 9'h010;
    xfer_len   = 10'd8;
    @(posedge clk);
    #1;
    start = 1'b0;
    bound = 0;
    while (dq.size() < 3 && bound < 30) begin
      @(posedge clk);
      #1;
      bound++;
    end
    check("rst_mid_3beats", dq.size(), 3);
    #2;
    rstn = 1'b0;
    #1;
    check("rst_busy",   {31'd0, busy},          32'd0);
    check("rst_done",   {31'd0, done},          32'd0);
    check("rst_re",     {31'd0, ram_re},        32'd0);
    check("rst_raddr",  {23'd0, ram_raddr},     32'd0);
    check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("rst_tdata",  {24'd0, m_axis_tdata},  32'd0);
    check("rst_tlast",  {31'd0, m_axis_tlast},  32'd0);
    check("rst_no_done", doneq.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    run_xfer("post_rst", 9'h010, 8, 0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = i[DW-1:0];
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("init_busy",   {31'd0, busy},          32'd0);
    check("init_done",   {31'd0, done},          32'd0);
    check("init_re",     {31'd0, ram_re},        32'd0);
    check("init_raddr",  {23'd0, ram_raddr},     32'd0);
    check("init_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("init_tdata",  {24'd0, m_axis_tdata},  32'd0);
    check("init_tlast",  {31'd0, m_axis_tlast},  32'd0);
    rstn = 1'b1;

    run_xfer("b2b",    9'h010, 8,   0, 1'b0);
    run_xfer("bp",     9'h010, 8,   1, 1'b0);
    run_xfer("wrap",   9'h1FE, 4,   0, 1'b0);
    run_xfer("len0",   9'h020, 0,   0, 1'b0);
    run_xfer("len1",   9'h033, 1,   0, 1'b0);
    run_xfer("len512", 9'h000, 512, 0, 1'b0);
    run_xfer("restart", 9'h010, 8,  0, 1'b1);
    reset_mid();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
